ram_slot_arbiter: RTL and testbench

- Time-slot arbiter for the shared 1024k main SRAM. Three requesters: the screen fetcher (attribute and bitmap reads), the Z80 memory cycle, and the STM32 DMA port (reached through the BUSRQ path).
- Sits between the CPU/video address muxes and the SRAM control pins. Drives a one-hot grant, the MA/MD mux select and the OE/WE strobes.
- Stalls the CPU via WAIT when a CPU cycle collides with a reserved video slot. Guarantees bounded DMA latency.

---
 rtl/ram_slot_arbiter_if.sv | 34 +++
 rtl/ram_slot_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ram_slot_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_slot_arbiter_if.sv
// Bus between the SRAM requesters (video, Z80, STM32 DMA) and the slot arbiter.
// master = requester/environment side, slave = arbiter side.
interface ram_slot_arbiter_if;
  // requester -> arbiter
  logic       LINE_SYNC;
  logic       VID_ACTIVE;
  logic       CPU_REQ;
  logic       CPU_WE;
  logic       DMA_REQ;
  logic       DMA_WE;
  logic [7:0] MD_IN;
  // arbiter -> SRAM pins / requesters
  logic       GNT_VID;
  logic       GNT_CPU;
  logic       GNT_DMA;
  logic       RAM_OE_N;
  logic       RAM_WE_N;
  logic       CPU_WAIT_N;
  logic       DMA_ACK;
  logic [7:0] DMA_RDATA;
  logic [3:0] PHASE;

  modport master (
    output LINE_SYNC, VID_ACTIVE, CPU_REQ, CPU_WE, DMA_REQ, DMA_WE, MD_IN,
    input  GNT_VID, GNT_CPU, GNT_DMA, RAM_OE_N, RAM_WE_N, CPU_WAIT_N,
           DMA_ACK, DMA_RDATA, PHASE
  );

  modport slave (
    input  LINE_SYNC, VID_ACTIVE, CPU_REQ, CPU_WE, DMA_REQ, DMA_WE, MD_IN,
    output GNT_VID, GNT_CPU, GNT_DMA, RAM_OE_N, RAM_WE_N, CPU_WAIT_N,
           DMA_ACK, DMA_RDATA, PHASE
  );
endinterface

// File: rtl/ram_slot_arbiter.sv
// Time-slot arbiter for the shared main SRAM.
// A free-running 16-phase counter reserves two phases per slot for the screen
// fetcher; the remaining phases go to the Z80 or to two-cycle DMA transfers.
// Every output is registered: the FSM decides at each edge what the *next*
// cycle looks like, so all reservation checks look at the next phase.
module ram_slot_arbiter #(
  parameter logic [3:0] PH_ATTR      = 4'd14,
  parameter logic [3:0] PH_BMP       = 4'd15,
  parameter int         DMA_MAX_WAIT = 48,
  parameter int         WAIT_W       = 6
) (
  input logic               CLK_14MHZ,
  input logic               RESET,
  ram_slot_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(DMA_MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU,
    S_VID,
    S_DMA_SETUP,
    S_DMA_STROBE
  } state_t;

  state_t            state, nxt;
  logic [3:0]        phase_q;
  logic [3:0]        ph_nxt, ph_nn;
  logic [WAIT_W-1:0] wait_cnt;
  logic              dma_we_q;

  // registered outputs and their next values
  logic       gnt_vid_q, gnt_cpu_q, gnt_dma_q;
  logic       oe_n_q, we_n_q, wait_n_q, ack_q;
  logic [7:0] rdata_q;
  logic       gnt_vid_d, gnt_cpu_d, gnt_dma_d;
  logic       oe_n_d, we_n_d, wait_n_d;

  logic rsv_next, pair_ok, dma_live, starved;

  function automatic logic is_rsv(input logic [3:0] ph, input logic va);
    return va && ((ph == PH_ATTR) || (ph == PH_BMP));
  endfunction

  // Phase arithmetic: the phase the next cycle will carry, and the one after.
  // LINE_SYNC wins over the increment so a sync never leaves a stale slot.
  always_comb begin
    ph_nxt = bus.LINE_SYNC ? 4'd0 : phase_q + 4'd1;
    ph_nn  = ph_nxt + 4'd1;
  end

  // Slot qualifiers. The request is masked during the strobe and the ACK
  // cycle because the requester is still holding DMA_REQ for the transfer
  // that is just finishing; it must not launch a second one.
  always_comb begin
    rsv_next = is_rsv(ph_nxt, bus.VID_ACTIVE);
    pair_ok  = !rsv_next && !is_rsv(ph_nn, bus.VID_ACTIVE);
    dma_live = bus.DMA_REQ && (state != S_DMA_STROBE) && !ack_q;
    starved  = dma_live && (wait_cnt == MAX_CNT);
  end

  // Phase counter: free-running, wraps 15->0.
  always_ff @(posedge CLK_14MHZ or posedge RESET) begin
    if (RESET) phase_q <= 4'd0;
    else       phase_q <= ph_nxt;
  end

  // FSM state register.
  always_ff @(posedge CLK_14MHZ or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= nxt;
  end

  // FSM next state: video > starved DMA > CPU > ordinary DMA.
  // A DMA pair is only started when both of its cycles fall on free phases.
  always_comb begin
    nxt = S_IDLE;
    if (state == S_DMA_SETUP)        nxt = S_DMA_STROBE;
    else if (rsv_next)               nxt = S_VID;
    else if (starved && pair_ok)     nxt = S_DMA_SETUP;
    else if (bus.CPU_REQ)            nxt = S_CPU;
    else if (dma_live && pair_ok)    nxt = S_DMA_SETUP;
    else                             nxt = S_IDLE;
  end

  // FSM outputs for the next cycle. CPU direction is taken from the request
  // being granted; DMA direction comes from the latched copy.
  always_comb begin
    gnt_vid_d = (nxt == S_VID);
    gnt_cpu_d = (nxt == S_CPU);
    gnt_dma_d = (nxt == S_DMA_SETUP) || (nxt == S_DMA_STROBE);
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    case (nxt)
      S_VID:        oe_n_d = 1'b0;
      S_CPU:        begin
                      oe_n_d = bus.CPU_WE;
                      we_n_d = !bus.CPU_WE;
                    end
      S_DMA_STROBE: begin
                      oe_n_d = dma_we_q;
                      we_n_d = !dma_we_q;
                    end
      default:      ;
    endcase
    // WAIT tracks the ownership of the coming cycle against the live request.
    wait_n_d  = !(bus.CPU_REQ && (nxt != S_CPU));
  end

  // Output registers; ACK follows the strobe cycle, read data is captured
  // from the bus at the end of a read strobe and held until the next read.
  always_ff @(posedge CLK_14MHZ or posedge RESET) begin
    if (RESET) begin
      gnt_vid_q <= 1'b0;
      gnt_cpu_q <= 1'b0;
      gnt_dma_q <= 1'b0;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      wait_n_q  <= 1'b1;
      ack_q     <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      gnt_vid_q <= gnt_vid_d;
      gnt_cpu_q <= gnt_cpu_d;
      gnt_dma_q <= gnt_dma_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      wait_n_q  <= wait_n_d;
      ack_q     <= (state == S_DMA_STROBE);
      if ((state == S_DMA_STROBE) && !dma_we_q) rdata_q <= bus.MD_IN;
    end
  end

  // Latch DMA direction at pair start so the strobe and capture agree.
  always_ff @(posedge CLK_14MHZ or posedge RESET) begin
    if (RESET)                   dma_we_q <= 1'b0;
    else if (nxt == S_DMA_SETUP) dma_we_q <= bus.DMA_WE;
  end

  // Starvation counter: cycles a request has waited without a grant,
  // saturating; cleared by the completion pulse.
  always_ff @(posedge CLK_14MHZ or posedge RESET) begin
    if (RESET)                                           wait_cnt <= '0;
    else if (ack_q)                                      wait_cnt <= '0;
    else if (bus.DMA_REQ && !gnt_dma_q && wait_cnt != MAX_CNT)
                                                         wait_cnt <= wait_cnt + 1'b1;
  end

  assign bus.GNT_VID    = gnt_vid_q;
  assign bus.GNT_CPU    = gnt_cpu_q;
  assign bus.GNT_DMA    = gnt_dma_q;
  assign bus.RAM_OE_N   = oe_n_q;
  assign bus.RAM_WE_N   = we_n_q;
  assign bus.CPU_WAIT_N = wait_n_q;
  assign bus.DMA_ACK    = ack_q;
  assign bus.DMA_RDATA  = rdata_q;
  assign bus.PHASE      = phase_q;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Directed bench for ram_slot_arbiter: reset, video slots, CPU collision,
// DMA read/write, slot boundary, sync during a pair, starvation, reset mid-DMA.
module tb_ram_slot_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] ph;          // reference phase
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_slot_arbiter_if bus();

  ram_slot_arbiter dut (
    .CLK_14MHZ (clk),
    .RESET     (rst),
    .bus       (bus)
  );

  // Reference phase: counts every edge, LINE_SYNC forces 0.
  always @(posedge clk or posedge rst) begin
    if (rst) ph <= 4'd0;
    else     ph <= bus.LINE_SYNC ? 4'd0 : ph + 4'd1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic to_phase(input logic [3:0] p);
    for (int i = 0; i < 40 && ph != p; i++) @(negedge clk);
    chk("phase_align", bus.PHASE, p);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt_vid"}, bus.GNT_VID, 0);
    chk({tag, "_gnt_cpu"}, bus.GNT_CPU, 0);
    chk({tag, "_gnt_dma"}, bus.GNT_DMA, 0);
    chk({tag, "_oe_n"},    bus.RAM_OE_N, 1);
    chk({tag, "_we_n"},    bus.RAM_WE_N, 1);
    chk({tag, "_wait_n"},  bus.CPU_WAIT_N, 1);
    chk({tag, "_ack"},     bus.DMA_ACK, 0);
    chk({tag, "_rdata"},   bus.DMA_RDATA, 8'h00);
    chk({tag, "_phase"},   bus.PHASE, 0);
  endtask

  initial begin
    logic e_dma [6];
    logic e_vid [6];
    logic e_ack [6];
    int   n;
    logic found;

    rst = 1'b1;
    bus.LINE_SYNC = 0; bus.VID_ACTIVE = 0; bus.CPU_REQ = 0; bus.CPU_WE = 0;
    bus.DMA_REQ = 0; bus.DMA_WE = 0; bus.MD_IN = 8'h00;
    step(); step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();
    chk("rst_release_phase", bus.PHASE, 1);

    // Idle line: video slots at phases 14/15 only
    bus.VID_ACTIVE = 1;
    step();
    for (int i = 0; i < 32; i++) begin
      step();
      chk("idle_gnt_vid", bus.GNT_VID, (ph >= 4'd14));
      chk("idle_oe_n",    bus.RAM_OE_N, (ph < 4'd14));
      chk("idle_gnt_cpu", bus.GNT_CPU, 0);
      chk("idle_gnt_dma", bus.GNT_DMA, 0);
    end

    // CPU collision with the video slot
    to_phase(4'd13);
    bus.CPU_REQ = 1; bus.CPU_WE = 0;
    step();
    chk("col14_gnt_cpu", bus.GNT_CPU, 0);
    chk("col14_wait_n",  bus.CPU_WAIT_N, 0);
    chk("col14_gnt_vid", bus.GNT_VID, 1);
    step();
    chk("col15_gnt_cpu", bus.GNT_CPU, 0);
    chk("col15_wait_n",  bus.CPU_WAIT_N, 0);
    step();
    chk("col0_phase",   bus.PHASE, 0);
    chk("col0_gnt_cpu", bus.GNT_CPU, 1);
    chk("col0_wait_n",  bus.CPU_WAIT_N, 1);
    chk("col0_oe_n",    bus.RAM_OE_N, 0);
    chk("col0_gnt_vid", bus.GNT_VID, 0);
    bus.CPU_WE = 1;
    step();
    chk("cpuwr_gnt_cpu", bus.GNT_CPU, 1);
    chk("cpuwr_we_n",    bus.RAM_WE_N, 0);
    chk("cpuwr_oe_n",    bus.RAM_OE_N, 1);
    bus.CPU_REQ = 0; bus.CPU_WE = 0;
    step();
    chk("cpuoff_gnt_cpu", bus.GNT_CPU, 0);
    chk("cpuoff_wait_n",  bus.CPU_WAIT_N, 1);
    chk("cpuoff_we_n",    bus.RAM_WE_N, 1);

    // LINE_SYNC clears the phase
    bus.LINE_SYNC = 1;
    step();
    chk("sync_phase0", bus.PHASE, 0);
    bus.LINE_SYNC = 0;
    step();
    chk("sync_phase1", bus.PHASE, 1);

    // DMA read, video off
    bus.VID_ACTIVE = 0; bus.DMA_REQ = 1; bus.DMA_WE = 0; bus.MD_IN = 8'hA5;
    step();
    chk("dmard_setup_gnt", bus.GNT_DMA, 1);
    chk("dmard_setup_oe",  bus.RAM_OE_N, 1);
    chk("dmard_setup_we",  bus.RAM_WE_N, 1);
    chk("dmard_setup_ack", bus.DMA_ACK, 0);
    step();
    chk("dmard_strb_gnt", bus.GNT_DMA, 1);
    chk("dmard_strb_oe",  bus.RAM_OE_N, 0);
    chk("dmard_strb_we",  bus.RAM_WE_N, 1);
    step();
    chk("dmard_ack",      bus.DMA_ACK, 1);
    chk("dmard_ack_gnt",  bus.GNT_DMA, 0);
    chk("dmard_rdata",    bus.DMA_RDATA, 8'hA5);
    bus.DMA_REQ = 0; bus.MD_IN = 8'h3C;
    step();
    chk("dmard_ack_pulse", bus.DMA_ACK, 0);
    chk("dmard_rdata_hold", bus.DMA_RDATA, 8'hA5);
    chk("dmard_no_repeat", bus.GNT_DMA, 0);

    // DMA write leaves read data untouched
    bus.DMA_REQ = 1; bus.DMA_WE = 1; bus.MD_IN = 8'h5A;
    step();
    chk("dmawr_setup_we", bus.RAM_WE_N, 1);
    chk("dmawr_setup_gnt", bus.GNT_DMA, 1);
    step();
    chk("dmawr_strb_we", bus.RAM_WE_N, 0);
    chk("dmawr_strb_oe", bus.RAM_OE_N, 1);
    step();
    chk("dmawr_ack",   bus.DMA_ACK, 1);
    chk("dmawr_rdata", bus.DMA_RDATA, 8'hA5);
    bus.DMA_REQ = 0; bus.DMA_WE = 0;
    step();

    // DMA boundary: request at phase 12 waits for phase 0
    bus.VID_ACTIVE = 1;
    to_phase(4'd12);
    bus.DMA_REQ = 1; bus.MD_IN = 8'hC3;
    e_dma = '{0, 0, 0, 1, 1, 0};   // phases 13,14,15,0,1,2
    e_vid = '{0, 1, 1, 0, 0, 0};
    e_ack = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bnd_gnt_dma", bus.GNT_DMA, e_dma[i]);
      chk("bnd_gnt_vid", bus.GNT_VID, e_vid[i]);
      chk("bnd_ack",     bus.DMA_ACK, e_ack[i]);
      if (i == 5) bus.DMA_REQ = 0;
    end
    chk("bnd_rdata", bus.DMA_RDATA, 8'hC3);

    // LINE_SYNC during the setup cycle: pair still completes
    bus.VID_ACTIVE = 0;
    to_phase(4'd5);
    bus.DMA_REQ = 1; bus.MD_IN = 8'h96;
    step();
    chk("syncdma_setup", bus.GNT_DMA, 1);
    bus.LINE_SYNC = 1;
    step();
    bus.LINE_SYNC = 0;
    chk("syncdma_strb_gnt", bus.GNT_DMA, 1);
    chk("syncdma_strb_oe",  bus.RAM_OE_N, 0);
    chk("syncdma_phase",    bus.PHASE, 0);
    step();
    chk("syncdma_ack",   bus.DMA_ACK, 1);
    chk("syncdma_rdata", bus.DMA_RDATA, 8'h96);
    bus.DMA_REQ = 0;
    step();

    // Starvation: CPU holds the bus, DMA must still get through
    bus.VID_ACTIVE = 1; bus.CPU_REQ = 1; bus.DMA_REQ = 1; bus.DMA_WE = 1;
    n = 0; found = 0;
    while (n < 48 + 18 && !found) begin
      step();
      n++;
      found = bus.GNT_DMA;
    end
    chk("starve_found", found, 1);
    chk("starve_not_early", (n >= 48), 1);
    chk("starve_setup_wait", bus.CPU_WAIT_N, 0);
    chk("starve_setup_cpu",  bus.GNT_CPU, 0);
    chk("starve_setup_ph",   (ph < 4'd14), 1);
    step();
    chk("starve_strb_gnt",  bus.GNT_DMA, 1);
    chk("starve_strb_we",   bus.RAM_WE_N, 0);
    chk("starve_strb_wait", bus.CPU_WAIT_N, 0);
    chk("starve_strb_ph",   (ph < 4'd14), 1);
    step();
    chk("starve_ack", bus.DMA_ACK, 1);
    bus.DMA_REQ = 0; bus.DMA_WE = 0; bus.CPU_REQ = 0;
    step();

    // Reset during the strobe: immediate reset values, no ACK afterwards
    bus.VID_ACTIVE = 0; bus.DMA_REQ = 1; bus.MD_IN = 8'h77;
    step();
    step();
    chk("rstdma_strb_gnt", bus.GNT_DMA, 1);
    chk("rstdma_strb_oe",  bus.RAM_OE_N, 0);
    #1 rst = 1'b1;
    #1 chk_reset_vals("rstdma");
    bus.DMA_REQ = 0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstdma_no_ack", bus.DMA_ACK, 0);
      chk("rstdma_phase",  bus.PHASE, 8'(i + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
